// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcodes, FSM state encoding and flag bit positions for
//               the ALU issue/writeback controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_DEC = 4'b0010;
  localparam logic [3:0] OP_INC = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NEG = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;
  localparam logic [3:0] OP_OR  = 4'b1000;
  localparam logic [3:0] OP_XOR = 4'b1100;
  localparam logic [3:0] OP_LDI = 4'b1111;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_IMM  = 2'd2;
  localparam state_t ST_WB   = 2'd3;

  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic is_alu_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_DEC, OP_INC, OP_AND,
      OP_NEG, OP_NOT, OP_OR, OP_XOR: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_regfile.sv
// ============================================================================
// Module      : alu_regfile
// Description : 4-entry register file, one write port, two operand read ports
//               and one debug read port, all reads combinational.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_regfile #(
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] REG_RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [1:0]        i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [1:0]        i_ra_addr,
  output logic [DATA_W-1:0] o_ra_data,
  input  logic [1:0]        i_rb_addr,
  output logic [DATA_W-1:0] o_rb_data,
  input  logic [1:0]        i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data
);

  logic [DATA_W-1:0] r_mem [0:3];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mem[gi] <= REG_RST_VAL;
        end else if (i_we && (i_waddr == 2'(gi))) begin
          r_mem[gi] <= i_wdata;
        end
      end
    end
  endgenerate

  assign o_ra_data  = r_mem[i_ra_addr];
  assign o_rb_data  = r_mem[i_rb_addr];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Issue/writeback controller in front of an 8-bit ALU; decodes
//               instruction bytes, sequences EXEC/WB and keeps Z/C/V flags.
//               Build option ALU_ZFLAG_ALL_EN: all ALU ops update Z.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] REG_RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [7:0]        instr,
  output logic              instr_ready,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  output logic              done,
  output logic              illegal,
  output logic [2:0]        flags,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            r_state;
  logic [3:0]        r_op;
  logic [1:0]        r_rd;
  logic [1:0]        r_rb;
  logic [DATA_W-1:0] r_data;
  logic [2:0]        r_flags;
  logic              r_illegal;
  logic [3:0]        r_alu_op;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;

  logic              w_exec;
  logic [3:0]        w_op;
  logic [DATA_W-1:0] w_ra_data;
  logic [DATA_W-1:0] w_rb_data;

  assign w_exec = (r_state == ST_EXEC);
  assign w_op   = instr[7:4];

  alu_regfile #(
    .DATA_W      (DATA_W),
    .REG_RST_VAL (REG_RST_VAL)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (r_state == ST_WB),
    .i_waddr    (r_rd),
    .i_wdata    (r_data),
    .i_ra_addr  (r_rd),
    .o_ra_data  (w_ra_data),
    .i_rb_addr  (r_rb),
    .o_rb_data  (w_rb_data),
    .i_dbg_addr (dbg_sel),
    .o_dbg_data (dbg_data)
  );

  // Operands go straight from the register file during EXEC so a write in the
  // preceding WB is already visible; outside EXEC the last values are held.
  assign alu_op      = w_exec ? r_op      : r_alu_op;
  assign alu_a       = w_exec ? w_ra_data : r_alu_a;
  assign alu_b       = w_exec ? w_rb_data : r_alu_b;
  assign instr_ready = (r_state == ST_IDLE) || (r_state == ST_IMM);
  assign done        = (r_state == ST_WB);
  assign illegal     = r_illegal;
  assign flags       = r_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_ADD;
      r_rd      <= 2'd0;
      r_rb      <= 2'd0;
      r_data    <= '0;
      r_flags   <= 3'b000;
      r_illegal <= 1'b0;
      r_alu_op  <= 4'b0000;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
    end else begin
      r_illegal <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (instr_valid) begin
            if (w_op == OP_LDI) begin
              r_rd    <= instr[3:2];
              r_state <= ST_IMM;
            end else if (is_alu_op(w_op)) begin
              r_op    <= w_op;
              r_rd    <= instr[3:2];
              r_rb    <= instr[1:0];
              r_state <= ST_EXEC;
            end else begin
              r_illegal <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          r_alu_op <= r_op;
          r_alu_a  <= w_ra_data;
          r_alu_b  <= w_rb_data;
          r_data   <= alu_result;
          if ((r_op == OP_ADD) || (r_op == OP_SUB)) begin
            r_flags[FLAG_Z] <= alu_zero;
            r_flags[FLAG_C] <= alu_carry;
            r_flags[FLAG_V] <= alu_overflow;
          end
`ifdef ALU_ZFLAG_ALL_EN
          else begin
            r_flags[FLAG_Z] <= (alu_result == '0);
          end
`endif
          r_state <= ST_WB;
        end
        ST_IMM: begin
          if (instr_valid) begin
            r_data  <= instr;
            r_state <= ST_WB;
          end
        end
        ST_WB: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
